mac_tx_source: RTL and testbench

Packet transmitter for the Ethernet sniffer's MAC transmit path. It is the source-side counterpart of the existing Avalon-ST sink on the MAC receive side. Software pushes 32-bit words into a word FIFO through an Avalon-MM slave, then commits a packet length. The block then streams exactly that many words to the MAC TX Avalon-ST sink, with sop, eop and empty framing under ready backpressure.

---
 rtl/mac_tx_pkg.sv | 22 ++
 rtl/tx_word_fifo.sv | 59 +++++
 rtl/mac_tx_source.sv | 175 +++++++++++++++++
 tb/tb_mac_tx_source.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tx_pkg.sv
// Shared constants and types for the MAC TX packet source.
// Register map, STATUS bit positions and the transmit FSM state.
package mac_tx_pkg;

  localparam int ADDR_DATA   = 0;
  localparam int ADDR_CTRL   = 1;
  localparam int ADDR_STATUS = 2;
  localparam int ADDR_TXCNT  = 3;

  localparam int ST_BUSY   = 16;
  localparam int ST_OVF    = 17;
  localparam int ST_CMDERR = 18;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SEND
  } tx_state_t;

endpackage

// File: rtl/tx_word_fifo.sv
// Synchronous show-ahead word FIFO; rdata is the current head.
// fill is one bit wider than the pointers so it can reach DEPTH.
module tx_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (fill_q == FW'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO still lands when a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    fill_d   = fill_q + FW'(do_push) - FW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mac_tx_source.sv
// Avalon-MM programmed packet source feeding the MAC TX Avalon-ST sink.
// Words are queued by software, then a committed length is streamed out.
module mac_tx_source #(
  parameter int DATAWIDTH          = 32,
  parameter int SLAVE_ADDRESSWIDTH = 3,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address,
  input  logic [DATAWIDTH-1:0]          slave_writedata,
  input  logic                          slave_write,
  input  logic                          slave_read,
  input  logic                          slave_chipselect,
  output logic [DATAWIDTH-1:0]          slave_readdata,
  output logic [31:0]                   tx_data,
  output logic                          tx_valid,
  output logic                          tx_sop,
  output logic                          tx_eop,
  output logic [1:0]                    tx_empty,
  input  logic                          tx_ready
);

  import mac_tx_pkg::*;

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FIFO_DEPTH);

  tx_state_t          state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         empty_q, empty_d;
  logic               ovf_q, ovf_d;
  logic               cmderr_q, cmderr_d;
  logic [31:0]        txcnt_q, txcnt_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;

  logic               wr_en, rd_en;
  logic               sel_data, sel_ctrl, sel_status, sel_txcnt;
  logic [LEN_W-1:0]   ctrl_len;
  logic [1:0]         ctrl_empty;
  logic               ctrl_ok;
  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [FW-1:0]      fifo_fill;
  logic [31:0]        fifo_rdata;
  logic [31:0]        status_word;
  logic               beat_eop;

  assign wr_en = slave_chipselect && slave_write;
  assign rd_en = slave_chipselect && slave_read && !slave_write;

  assign sel_data   = (slave_address == SLAVE_ADDRESSWIDTH'(ADDR_DATA));
  assign sel_ctrl   = (slave_address == SLAVE_ADDRESSWIDTH'(ADDR_CTRL));
  assign sel_status = (slave_address == SLAVE_ADDRESSWIDTH'(ADDR_STATUS));
  assign sel_txcnt  = (slave_address == SLAVE_ADDRESSWIDTH'(ADDR_TXCNT));

  assign ctrl_len   = slave_writedata[LEN_W-1:0];
  assign ctrl_empty = slave_writedata[17:16];
  assign ctrl_ok    = (state_q == IDLE) &&
                      (ctrl_len != '0) &&
                      (ctrl_len <= MAX_LEN);

  assign fifo_push = wr_en && sel_data;
  assign fifo_pop  = tx_valid && tx_ready && !fifo_empty;

  tx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (32'(slave_writedata)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fifo_fill)
  );

  // Stream outputs are forced low outside SEND so reset clears them at once.
  assign tx_valid = (state_q == SEND);
  assign beat_eop = tx_valid && (rem_q == LEN_W'(1));
  assign tx_sop   = tx_valid && (rem_q == len_q);
  assign tx_eop   = beat_eop;
  assign tx_empty = beat_eop ? empty_q : 2'b00;
  assign tx_data  = tx_valid ? fifo_rdata : 32'h0;

  assign slave_readdata = rdata_q;

  always_comb begin
    status_word = '0;
    status_word[FW-1:0]  = fifo_fill;
    status_word[ST_BUSY]   = (state_q != IDLE);
    status_word[ST_OVF]    = ovf_q;
    status_word[ST_CMDERR] = cmderr_q;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rem_d    = rem_q;
    empty_d  = empty_q;
    ovf_d    = ovf_q;
    cmderr_d = cmderr_q;
    txcnt_d  = txcnt_q;
    rdata_d  = rdata_q;

    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_en && sel_ctrl && !ctrl_ok) cmderr_d = 1'b1;
    if (wr_en && sel_status) begin
      if (slave_writedata[ST_OVF]) ovf_d = 1'b0;
      if (slave_writedata[ST_CMDERR]) cmderr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_en && sel_ctrl && ctrl_ok) begin
          state_d = ARMED;
          len_d   = ctrl_len;
          rem_d   = ctrl_len;
          empty_d = ctrl_empty;
        end
      end
      ARMED: begin
        // Wait for the whole packet so valid never gaps mid-packet.
        if (LEN_W'(fifo_fill) >= rem_q) state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (beat_eop) begin
            state_d = IDLE;
            txcnt_d = txcnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en && sel_txcnt) txcnt_d = '0;

    if (rd_en) begin
      unique case (1'b1)
        sel_status: rdata_d = DATAWIDTH'(status_word);
        sel_txcnt:  rdata_d = DATAWIDTH'(txcnt_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      empty_q  <= '0;
      ovf_q    <= 1'b0;
      cmderr_q <= 1'b0;
      txcnt_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      cmderr_q <= cmderr_d;
      txcnt_q  <= txcnt_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_source.sv
// Directed bench for mac_tx_source: register vectors from tables,
// stream beats checked against expected beat lists.
module tb_mac_tx_source;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata;
  logic        slave_write;
  logic        slave_read;
  logic        slave_chipselect;
  logic [31:0] slave_readdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_empty;
  logic        tx_ready;

  always #5 clk = ~clk;

  mac_tx_source #(
    .DATAWIDTH          (32),
    .SLAVE_ADDRESSWIDTH (3),
    .FIFO_DEPTH         (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_writedata  (slave_writedata),
    .slave_write      (slave_write),
    .slave_read       (slave_read),
    .slave_chipselect (slave_chipselect),
    .slave_readdata   (slave_readdata),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_sop           (tx_sop),
    .tx_eop           (tx_eop),
    .tx_empty         (tx_empty),
    .tx_ready         (tx_ready)
  );

  localparam int OP_WR  = 0;
  localparam int OP_RD  = 1;
  localparam int OP_NOP = 2;
  localparam int OP_RDY = 3;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_CTRL = 3'd1;
  localparam logic [2:0] A_STAT = 3'd2;
  localparam logic [2:0] A_TXC  = 3'd3;

  typedef struct {
    int          op;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] x;
    string       nm;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  e;
  } beat_t;

  vec_t  vq[$];
  beat_t got_q[$];
  beat_t exp_q[$];
  int    got_cyc[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      got_q.push_back({tx_data, tx_sop, tx_eop, tx_empty});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    slave_chipselect = 1'b1;
    slave_write      = 1'b1;
    slave_address    = a;
    slave_writedata  = d;
    tick();
    slave_chipselect = 1'b0;
    slave_write      = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    slave_chipselect = 1'b1;
    slave_read       = 1'b1;
    slave_address    = a;
    tick();
    slave_chipselect = 1'b0;
    slave_read       = 1'b0;
    d = slave_readdata;
  endtask

  task automatic add(input int op, input logic [2:0] a,
                     input logic [31:0] d, input logic [31:0] x,
                     input string nm);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.x = x; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic run_vecs();
    logic [31:0] r;
    foreach (vq[i]) begin
      case (vq[i].op)
        OP_WR:  wr(vq[i].a, vq[i].d);
        OP_RD: begin
          rd(vq[i].a, r);
          chk(vq[i].nm, r, vq[i].x);
        end
        OP_NOP: repeat (vq[i].d) tick();
        default: tx_ready = vq[i].d[0];
      endcase
    end
    vq.delete();
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic sop,
                          input logic eop, input logic [1:0] e);
    exp_q.push_back({d, sop, eop, e});
  endtask

  task automatic check_stream(input string nm, input bit back2back);
    int n;
    chk({nm, "_beats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", nm, i), got_q[i], exp_q[i]);
    if (back2back && got_q.size() > 1)
      chk({nm, "_gap"}, got_cyc[got_q.size()-1] - got_cyc[0],
          got_q.size() - 1);
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] snap_d;
    logic [3:0]  snap_f;
    logic [4:0]  pat;

    reset = 1'b1;
    slave_address = '0;
    slave_writedata = '0;
    slave_write = 1'b0;
    slave_read = 1'b0;
    slave_chipselect = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_outs", {tx_data, tx_sop, tx_eop, tx_empty, slave_readdata}, '0);

    // Basic three-word packet, empty=2
    add(OP_RD,  A_STAT, 0, 32'h0, "rst_status");
    add(OP_RD,  A_TXC,  0, 32'h0, "rst_txcnt");
    add(OP_WR,  A_DATA, 32'h11111111, 0, "");
    add(OP_WR,  A_DATA, 32'h22222222, 0, "");
    add(OP_WR,  A_DATA, 32'h33333333, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h3, "fill3");
    add(OP_WR,  A_CTRL, 32'h0002_0003, 0, "");
    add(OP_NOP, 0, 6, 0, "");
    add(OP_RD,  A_TXC,  0, 32'h1, "basic_txcnt");
    add(OP_RD,  A_STAT, 0, 32'h0, "basic_status");
    run_vecs();
    exp_beat(32'h11111111, 1, 0, 0);
    exp_beat(32'h22222222, 0, 0, 0);
    exp_beat(32'h33333333, 0, 1, 2);
    check_stream("basic", 1);

    // Command errors: len 0, len 17, CTRL while sending
    add(OP_WR,  A_CTRL, 32'h0, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0004_0000, "cmderr_len0");
    add(OP_WR,  A_STAT, 32'h0004_0000, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0, "cmderr_clr");
    add(OP_WR,  A_CTRL, 32'h11, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0004_0000, "cmderr_len17");
    add(OP_WR,  A_STAT, 32'h0004_0000, 0, "");
    add(OP_WR,  A_DATA, 32'hA1A1A1A1, 0, "");
    add(OP_WR,  A_DATA, 32'hA2A2A2A2, 0, "");
    add(OP_RDY, 0, 0, 0, "");
    add(OP_WR,  A_CTRL, 32'h0001_0002, 0, "");
    add(OP_NOP, 0, 2, 0, "");
    add(OP_WR,  A_CTRL, 32'h1, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0005_0002, "cmderr_send");
    add(OP_RDY, 0, 1, 0, "");
    add(OP_NOP, 0, 4, 0, "");
    add(OP_RD,  A_TXC,  0, 32'h2, "cmd_txcnt");
    add(OP_RD,  A_STAT, 0, 32'h0004_0000, "cmd_idle");
    add(OP_WR,  A_STAT, 32'h0004_0000, 0, "");
    run_vecs();
    exp_beat(32'hA1A1A1A1, 1, 0, 0);
    exp_beat(32'hA2A2A2A2, 0, 1, 1);
    check_stream("cmd", 1);

    // Backpressure: ready 1,0,0,1,1 from the first valid cycle
    wr(A_DATA, 32'hB1B1B1B1);
    wr(A_DATA, 32'hB2B2B2B2);
    wr(A_DATA, 32'hB3B3B3B3);
    wr(A_CTRL, 32'h0002_0003);
    tick();
    pat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      tx_ready = pat[i];
      @(negedge clk);
      if (i == 1) begin
        chk("bp_valid1", tx_valid, 1'b1);
        snap_d = tx_data;
        snap_f = {tx_sop, tx_eop, tx_empty};
      end
      if (i == 2) begin
        chk("bp_valid2", tx_valid, 1'b1);
        chk("bp_hold_data", tx_data, snap_d);
        chk("bp_hold_flags", {tx_sop, tx_eop, tx_empty}, snap_f);
      end
      tick();
    end
    tx_ready = 1'b1;
    add(OP_NOP, 0, 2, 0, "");
    add(OP_RD,  A_TXC, 0, 32'h3, "bp_txcnt");
    run_vecs();
    exp_beat(32'hB1B1B1B1, 1, 0, 0);
    exp_beat(32'hB2B2B2B2, 0, 0, 0);
    exp_beat(32'hB3B3B3B3, 0, 1, 2);
    check_stream("bp", 0);

    // Overflow: 17 pushes into 16 slots, then a full-depth packet
    for (int i = 0; i < 17; i++)
      add(OP_WR, A_DATA, 32'hC000_0000 + 32'(i), 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0002_0010, "ovf_set");
    add(OP_WR,  A_STAT, 32'h0002_0000, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0000_0010, "ovf_clr");
    add(OP_WR,  A_CTRL, 32'h0000_0010, 0, "");
    add(OP_NOP, 0, 22, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0, "ovf_drained");
    add(OP_RD,  A_TXC,  0, 32'h4, "ovf_txcnt");
    add(OP_WR,  A_TXC,  32'hDEAD_BEEF, 0, "");
    add(OP_RD,  A_TXC,  0, 32'h0, "txcnt_wclr");
    run_vecs();
    for (int i = 0; i < 16; i++)
      exp_beat(32'hC000_0000 + 32'(i), i == 0, i == 15, 0);
    check_stream("ovf", 1);

    // Armed before data: words arrive at t-1 and t, valid at t+2
    wr(A_CTRL, 32'h2);
    tick();
    tick();
    chk("armed_wait", tx_valid, 1'b0);
    wr(A_DATA, 32'hE1E1E1E1);
    wr(A_DATA, 32'hE2E2E2E2);
    @(negedge clk);
    chk("armed_t1", tx_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("armed_t2", {tx_valid, tx_sop, tx_data}, {2'b11, 32'hE1E1E1E1});
    tick();
    add(OP_NOP, 0, 2, 0, "");
    add(OP_RD,  A_TXC, 0, 32'h1, "armed_txcnt");
    run_vecs();
    exp_beat(32'hE1E1E1E1, 1, 0, 0);
    exp_beat(32'hE2E2E2E2, 0, 1, 0);
    check_stream("armed", 1);

    // Asynchronous reset while a packet is being offered
    wr(A_DATA, 32'hF1F1F1F1);
    wr(A_DATA, 32'hF2F2F2F2);
    tx_ready = 1'b0;
    wr(A_CTRL, 32'h2);
    tick();
    @(negedge clk);
    chk("pre_rst_valid", tx_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", tx_valid, 1'b0);
    chk("rst_async_outs", {tx_data, tx_sop, tx_eop, tx_empty}, '0);
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    add(OP_NOP, 0, 3, 0, "");
    add(OP_RD,  A_STAT, 0, 32'h0, "post_rst_status");
    add(OP_RD,  A_TXC,  0, 32'h0, "post_rst_txcnt");
    run_vecs();
    check_stream("rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
